// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback
// with a memory req/ready handshake, bus timeout and illegal-opcode exception. Optional macro: MIPS_MC_LOADEXT_EN.
module mips_mc_ctrl #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               irwrite,
  output logic               pcwrite,
  output logic               branch,
  output logic               ne,
  output logic [1:0]         pcsrc,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               zeroext,
  output logic [ALUOP_W-1:0] aluop,
  output logic [1:0]         regdst,
  output logic [1:0]         memtoreg,
  output logic               regwrite,
  output logic               memwrite,
  output logic               exc,
  output logic [1:0]         exc_cause
`ifdef MIPS_MC_LOADEXT_EN
  ,
  output logic [1:0]         ldsize,
  output logic               ldunsigned
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_MC_LOADEXT_EN
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
`endif
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
    S_ALUWB, S_BREX, S_IMMEX, S_JEX, S_JALEX, S_JREX, S_EXC
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       pcwrite;
    logic       branch;
    logic       ne;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [3:0] aluop;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       memwrite;
    logic       exc;
`ifdef MIPS_MC_LOADEXT_EN
    logic [1:0] ldsize;
    logic       ldunsigned;
`endif
  } ctl_t;

  state_t           state, nxt;
  ctl_t             ctl_q, ctl;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       exc_cause_q, cause_nxt;
  logic             is_mem_state, timeout, fetch_hit;

  // Control word for a state; op/funct come from the IR, which is stable for the whole instruction.
  function automatic ctl_t decode(input state_t s, input logic [5:0] o, input logic [5:0] f);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_req = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEMWB: begin
        c.memtoreg = 2'b01;
        c.regwrite = 1'b1;
`ifdef MIPS_MC_LOADEXT_EN
        case (o)
          OP_LH, OP_LHU: c.ldsize = 2'b01;
          OP_LB, OP_LBU: c.ldsize = 2'b10;
          default:       c.ldsize = 2'b00;
        endcase
        c.ldunsigned = (o == OP_LBU) || (o == OP_LHU);
`endif
      end
      S_MEMWR:   begin c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = 1'b1; end
      S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 4'b1111; end
      S_ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = (o == OP_RTYPE) ? 2'b01 : 2'b00;
      end
      S_BREX: begin
        c.alusrca = 1'b1;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
        c.ne      = (o == OP_BNE);
        case (o)
          OP_BLEZ: c.aluop = 4'b0010;
          OP_BGTZ: c.aluop = 4'b1110;
          default: c.aluop = 4'b0001;
        endcase
      end
      S_IMMEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.zeroext = (o == OP_ANDI) || (o == OP_ORI) || (o == OP_XORI) || (o == OP_SLTIU);
        case (o)
          OP_SLTI:  c.aluop = 4'b0110;
          OP_SLTIU: c.aluop = 4'b1000;
          OP_ANDI:  c.aluop = 4'b0111;
          OP_ORI:   c.aluop = 4'b0011;
          OP_XORI:  c.aluop = 4'b0101;
          OP_LUI:   c.aluop = 4'b0100;
          default:  c.aluop = 4'b0000;
        endcase
      end
      S_JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      S_JALEX: begin
        c.pcsrc = 2'b10; c.pcwrite = 1'b1;
        c.regdst = 2'b10; c.memtoreg = 2'b10; c.regwrite = 1'b1;
      end
      S_JREX: begin
        c.pcsrc   = 2'b11;
        c.pcwrite = 1'b1;
        if (f == FN_JALR) begin
          c.regdst = 2'b01; c.memtoreg = 2'b10; c.regwrite = 1'b1;
        end
      end
      S_EXC:     c.exc = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

  assign is_mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout      = (MEM_TIMEOUT != 0) && !mem_ready && (cnt == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    // NOTE: defaults first so every path assigns nxt and cause_nxt; otherwise latches are inferred.
    nxt       = state;
    cause_nxt = CAUSE_ILLEGAL;
    case (state)
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          case (state)
            S_FETCH: nxt = S_DECODE;
            S_MEMRD: nxt = S_MEMWB;
            default: nxt = S_FETCH;
          endcase
        end else if (timeout) begin
          nxt       = S_EXC;
          cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (op)
          OP_RTYPE: nxt = (funct == FN_JR || funct == FN_JALR) ? S_JREX : S_RTYPEEX;
          OP_LW, OP_SW: nxt = S_MEMADR;
`ifdef MIPS_MC_LOADEXT_EN
          OP_LB, OP_LH, OP_LBU, OP_LHU: nxt = S_MEMADR;
`endif
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: nxt = S_BREX;
          OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: nxt = S_IMMEX;
          OP_J:    nxt = S_JEX;
          OP_JAL:  nxt = S_JALEX;
          default: nxt = S_EXC;
        endcase
      end
      S_MEMADR:  nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_RTYPEEX: nxt = S_ALUWB;
      S_IMMEX:   nxt = S_ALUWB;
      default:   nxt = S_FETCH;
    endcase
  end

  // Control word is registered from the next state, so it lines up with the state it belongs to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      cnt         <= '0;
      exc_cause_q <= 2'b00;
      ctl_q       <= decode(S_FETCH, 6'd0, 6'd0);
    end else begin
      // NOTE: non-blocking for all state so every flop samples pre-edge values.
      state <= nxt;
      ctl_q <= decode(nxt, op, funct);
      if (nxt != state)
        cnt <= '0;
      else if (is_mem_state && !mem_ready && (cnt != '1))
        cnt <= cnt + 1'b1;
      if (nxt == S_EXC)
        exc_cause_q <= cause_nxt;
    end
  end

  // Outputs read zero for as long as reset is held, including the FETCH word preloaded at reset.
  assign ctl       = reset_n ? ctl_q : '0;
  assign fetch_hit = reset_n && (state == S_FETCH) && mem_ready;

  assign mem_req   = ctl.mem_req;
  assign iord      = ctl.iord;
  assign irwrite   = fetch_hit;
  assign pcwrite   = ctl.pcwrite | fetch_hit;
  assign branch    = ctl.branch;
  assign ne        = ctl.ne;
  assign pcsrc     = ctl.pcsrc;
  assign alusrca   = ctl.alusrca;
  assign alusrcb   = ctl.alusrcb;
  assign zeroext   = ctl.zeroext;
  assign aluop     = ALUOP_W'(ctl.aluop);
  assign regdst    = ctl.regdst;
  assign memtoreg  = ctl.memtoreg;
  assign regwrite  = ctl.regwrite;
  assign memwrite  = ctl.memwrite;
  assign exc       = ctl.exc;
  assign exc_cause = reset_n ? exc_cause_q : 2'b00;
`ifdef MIPS_MC_LOADEXT_EN
  assign ldsize     = ctl.ldsize;
  assign ldunsigned = ctl.ldunsigned;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: the stimulus queues one hand-written control word per cycle,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b1;
  logic       mem_req, iord, irwrite, pcwrite, branch, ne, alusrca, zeroext;
  logic       regwrite, memwrite, exc;
  logic [1:0] pcsrc, alusrcb, regdst, memtoreg, exc_cause;
  logic [3:0] aluop;

  mips_mc_ctrl #(.ALUOP_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .ne(ne), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .zeroext(zeroext), .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .memwrite(memwrite), .exc(exc), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       ne;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [3:0] aluop;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       memwrite;
    logic       exc;
    logic [1:0] exc_cause;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } item_t;

  item_t      sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] cause = 2'b00;
  item_t      mon_it;
  exp_t       mon_act;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_it = sb.pop_front();
      mon_act.mem_req   = mem_req;   mon_act.iord     = iord;
      mon_act.irwrite   = irwrite;   mon_act.pcwrite  = pcwrite;
      mon_act.branch    = branch;    mon_act.ne       = ne;
      mon_act.pcsrc     = pcsrc;     mon_act.alusrca  = alusrca;
      mon_act.alusrcb   = alusrcb;   mon_act.zeroext  = zeroext;
      mon_act.aluop     = aluop;     mon_act.regdst   = regdst;
      mon_act.memtoreg  = memtoreg;  mon_act.regwrite = regwrite;
      mon_act.memwrite  = memwrite;  mon_act.exc      = exc;
      mon_act.exc_cause = exc_cause;
      checks++;
      if (mon_act !== mon_it.e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", mon_it.name, mon_act, mon_it.e);
      end
    end
  end

  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.exc_cause = cause;
    return e;
  endfunction

  function automatic exp_t fe(input logic rdy);
    exp_t e;
    e = base();
    e.mem_req = 1'b1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy;
    return e;
  endfunction

  // One cycle: drive inputs, queue the expected control word, advance to just after the next edge.
  task automatic cyc(input string name, input logic rdy, input exp_t e);
    item_t it;
    mem_ready = rdy;
    it.name = name;
    it.e    = e;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic front(input string n, input logic [5:0] o, input logic [5:0] f, input int waits);
    exp_t e;
    op = o;
    funct = f;
    for (int i = 0; i < waits; i++) cyc({n, "/fetch_wait"}, 1'b0, fe(1'b0));
    cyc({n, "/fetch"}, 1'b1, fe(1'b1));
    e = base(); e.alusrcb = 2'b11;
    cyc({n, "/decode"}, 1'b1, e);
  endtask

  task automatic run_rtype(input string n, input logic [5:0] f);
    exp_t e;
    front(n, 6'b000000, f, 0);
    e = base(); e.alusrca = 1'b1; e.aluop = 4'b1111;
    cyc({n, "/rtypeex"}, 1'b1, e);
    e = base(); e.regwrite = 1'b1; e.regdst = 2'b01;
    cyc({n, "/aluwb"}, 1'b1, e);
  endtask

  task automatic run_imm(input string n, input logic [5:0] o, input logic [3:0] a, input logic z);
    exp_t e;
    front(n, o, 6'd0, 0);
    e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = a; e.zeroext = z;
    cyc({n, "/immex"}, 1'b1, e);
    e = base(); e.regwrite = 1'b1;
    cyc({n, "/aluwb"}, 1'b1, e);
  endtask

  task automatic run_mem(input string n, input logic [5:0] o, input int waits);
    exp_t e;
    front(n, o, 6'd0, 0);
    e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
    cyc({n, "/memadr"}, 1'b1, e);
    e = base(); e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = (o == 6'b101011);
    for (int i = 0; i < waits; i++) cyc({n, "/mem_wait"}, 1'b0, e);
    cyc({n, "/mem"}, 1'b1, e);
    if (o == 6'b100011) begin
      e = base(); e.memtoreg = 2'b01; e.regwrite = 1'b1;
      cyc({n, "/memwb"}, 1'b1, e);
    end
  endtask

  task automatic run_br(input string n, input logic [5:0] o, input logic [3:0] a, input logic nev);
    exp_t e;
    front(n, o, 6'd0, 0);
    e = base(); e.alusrca = 1'b1; e.pcsrc = 2'b01; e.branch = 1'b1; e.aluop = a; e.ne = nev;
    cyc({n, "/brex"}, 1'b1, e);
  endtask

  task automatic run_jmp(input string n, input logic [5:0] o, input logic [5:0] f, input int waits,
                         input logic [1:0] pcs, input logic lnk, input logic [1:0] dst);
    exp_t e;
    front(n, o, f, waits);
    e = base(); e.pcsrc = pcs; e.pcwrite = 1'b1; e.regwrite = lnk; e.regdst = dst;
    e.memtoreg = lnk ? 2'b10 : 2'b00;
    cyc({n, "/jex"}, 1'b1, e);
  endtask

  task automatic run_illegal(input string n, input logic [5:0] o);
    exp_t e;
    front(n, o, 6'd0, 0);
    cause = 2'b01;
    e = base(); e.exc = 1'b1;
    cyc({n, "/exc"}, 1'b1, e);
  endtask

  initial begin
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc("reset", 1'b1, '0);
    reset_n = 1'b1;

    run_rtype("add", 6'b100000);
    run_mem("lw_wait3", 6'b100011, 3);
    run_mem("sw", 6'b101011, 0);
    run_imm("ori", 6'b001101, 4'b0011, 1'b1);
    run_imm("addi", 6'b001000, 4'b0000, 1'b0);
    run_imm("lui", 6'b001111, 4'b0100, 1'b0);
    run_imm("sltiu", 6'b001011, 4'b1000, 1'b1);
    run_br("beq", 6'b000100, 4'b0001, 1'b0);
    run_br("bne", 6'b000101, 4'b0001, 1'b1);
    run_br("blez", 6'b000110, 4'b0010, 1'b0);
    run_br("bgtz", 6'b000111, 4'b1110, 1'b0);
    run_jmp("j_wait15", 6'b000010, 6'd0, 15, 2'b10, 1'b0, 2'b00);
    run_jmp("jal", 6'b000011, 6'd0, 0, 2'b10, 1'b1, 2'b10);
    run_jmp("jr", 6'b000000, 6'b001000, 0, 2'b11, 1'b0, 2'b00);
    run_jmp("jalr", 6'b000000, 6'b001001, 0, 2'b11, 1'b1, 2'b01);
    run_illegal("op3f", 6'b111111);
    run_illegal("lb_noext", 6'b100000);
    run_imm("andi", 6'b001100, 4'b0111, 1'b1);

    // Memory never answers the fetch: sixteen waiting cycles, then the timeout exception.
    op = 6'b000000;
    funct = 6'b100110;
    for (int i = 0; i < 16; i++) cyc("timeout/fetch_wait", 1'b0, fe(1'b0));
    cause = 2'b10;
    e = base(); e.exc = 1'b1;
    cyc("timeout/exc", 1'b0, e);
    run_rtype("xor_refetch", 6'b100110);

    // Reset in the middle of a load wait abandons it and clears the exception cause.
    front("lw_abort", 6'b100011, 6'd0, 0);
    e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
    cyc("lw_abort/memadr", 1'b1, e);
    e = base(); e.mem_req = 1'b1; e.iord = 1'b1;
    cyc("lw_abort/mem_wait", 1'b0, e);
    reset_n = 1'b0;
    cause = 2'b00;
    cyc("lw_abort/reset", 1'b1, '0);
    reset_n = 1'b1;
    run_mem("sw_after_reset", 6'b101011, 1);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
